// File: rtl/jtag_cmd_rx.sv
// jtag_cmd_rx: host-to-target half of the JTAG UART debug link. Hunts for a sync byte, assembles
// five payload bytes (LSB first) into a 40-bit command word and holds it in a one-entry valid/ready slot.
// Optional trailing checksum byte: define JTAG_CMD_RX_CHECKSUM_EN.
module jtag_cmd_rx #(
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter logic [23:0] TIMEOUT_CYC = 24'd9000000,
  parameter int          CNT_W       = 16
) (
  input  logic             CLK_50,
  input  logic             RESET,
  input  logic [7:0]       RX_DATA,
  input  logic             RX_VALID,
  output logic [39:0]      CMD_OUT,
  output logic             CMD_VALID,
  input  logic             CMD_READY,
  output logic             OVERRUN,
  output logic             TIMEOUT,
  output logic             CSUM_ERR,
  output logic [2:0]       BYTE_CNT,
  output logic [CNT_W-1:0] FRAME_CNT
);

`ifdef JTAG_CMD_RX_CHECKSUM_EN
  typedef enum logic [1:0] {HUNT = 2'd0, PAYLOAD = 2'd1, CHECK = 2'd2} state_t;
`else
  typedef enum logic [1:0] {HUNT = 2'd0, PAYLOAD = 2'd1} state_t;
`endif

  state_t      state;
  logic [39:0] shift_reg;
  logic [23:0] idle_cnt;
  logic [39:0] next_word;
  logic [39:0] deliver_word;
  logic        deliver;
  logic        csum_bad;
  logic        timed_out;
  logic        slot_free;

  // Current byte dropped into its lane of the partially assembled word.
  always_comb begin
    next_word = shift_reg;
    case (BYTE_CNT)
      3'd0:    next_word[7:0]   = RX_DATA;
      3'd1:    next_word[15:8]  = RX_DATA;
      3'd2:    next_word[23:16] = RX_DATA;
      3'd3:    next_word[31:24] = RX_DATA;
      3'd4:    next_word[39:32] = RX_DATA;
      default: next_word = shift_reg;
    endcase
  end

`ifdef JTAG_CMD_RX_CHECKSUM_EN
  logic [7:0] payload_sum;

  assign payload_sum  = shift_reg[7:0] + shift_reg[15:8] + shift_reg[23:16]
                      + shift_reg[31:24] + shift_reg[39:32];
  assign deliver      = (state == CHECK) && RX_VALID && (RX_DATA == payload_sum);
  assign csum_bad     = (state == CHECK) && RX_VALID && (RX_DATA != payload_sum);
  assign deliver_word = shift_reg;
`else
  assign deliver      = (state == PAYLOAD) && RX_VALID && (BYTE_CNT == 3'd4);
  assign csum_bad     = 1'b0;
  assign deliver_word = next_word;
`endif

  // Expires on the TIMEOUT_CYC-th consecutive idle cycle inside a frame; a byte that cycle wins.
  assign timed_out = (TIMEOUT_CYC != 24'd0) && (state != HUNT) && !RX_VALID
                   && (idle_cnt == TIMEOUT_CYC - 24'd1);

  assign slot_free = !CMD_VALID || CMD_READY;

  always_ff @(posedge CLK_50) begin
    if (RESET) begin
      state     <= HUNT;
      shift_reg <= '0;
      idle_cnt  <= '0;
      CMD_OUT   <= '0;
      CMD_VALID <= 1'b0;
      OVERRUN   <= 1'b0;
      TIMEOUT   <= 1'b0;
      CSUM_ERR  <= 1'b0;
      BYTE_CNT  <= '0;
      FRAME_CNT <= '0;
    end else begin
      OVERRUN  <= 1'b0;
      TIMEOUT  <= 1'b0;
      CSUM_ERR <= 1'b0;

      case (state)
        HUNT: begin
          idle_cnt <= '0;
          BYTE_CNT <= '0;
          if (RX_VALID && (RX_DATA == SYNC_BYTE)) begin
            state     <= PAYLOAD;
            shift_reg <= '0;
          end
        end

        PAYLOAD: begin
          if (RX_VALID) begin
            idle_cnt  <= '0;
            shift_reg <= next_word;
            BYTE_CNT  <= BYTE_CNT + 3'd1;
            if (BYTE_CNT == 3'd4) begin
`ifdef JTAG_CMD_RX_CHECKSUM_EN
              state <= CHECK;
`else
              state    <= HUNT;
              BYTE_CNT <= '0;
`endif
            end
          end else if (timed_out) begin
            TIMEOUT  <= 1'b1;
            BYTE_CNT <= '0;
            idle_cnt <= '0;
            state    <= HUNT;
          end else begin
            idle_cnt <= idle_cnt + 24'd1;
          end
        end

`ifdef JTAG_CMD_RX_CHECKSUM_EN
        CHECK: begin
          if (RX_VALID) begin
            idle_cnt <= '0;
            BYTE_CNT <= '0;
            CSUM_ERR <= csum_bad;
            state    <= HUNT;
          end else if (timed_out) begin
            TIMEOUT  <= 1'b1;
            BYTE_CNT <= '0;
            idle_cnt <= '0;
            state    <= HUNT;
          end else begin
            idle_cnt <= idle_cnt + 24'd1;
          end
        end
`endif

        default: begin
          state    <= HUNT;
          BYTE_CNT <= '0;
          idle_cnt <= '0;
        end
      endcase

      // A frame completing into a full, unconsumed slot is dropped rather than overwriting it.
      if (deliver) begin
        if (slot_free) begin
          CMD_OUT   <= deliver_word;
          CMD_VALID <= 1'b1;
          FRAME_CNT <= FRAME_CNT + CNT_W'(1);
        end else begin
          OVERRUN <= 1'b1;
        end
      end else if (CMD_VALID && CMD_READY) begin
        CMD_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jtag_cmd_rx.sv
// tb_jtag_cmd_rx: vector table, directed corner sequences and a randomized run against a
// frame-level reference model of jtag_cmd_rx (honours JTAG_CMD_RX_CHECKSUM_EN).
module tb_jtag_cmd_rx;

  localparam int TO_CYC = 10;
`ifdef JTAG_CMD_RX_CHECKSUM_EN
  localparam int FRAME_BYTES = 6;
`else
  localparam int FRAME_BYTES = 5;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        cmd_ready = 1'b0;
  logic [39:0] cmd_out;
  logic        cmd_valid;
  logic        overrun;
  logic        timeout;
  logic        csum_err;
  logic [2:0]  byte_cnt;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  jtag_cmd_rx #(
    .SYNC_BYTE  (8'hA5),
    .TIMEOUT_CYC(24'(TO_CYC)),
    .CNT_W      (16)
  ) dut (
    .CLK_50   (clk),
    .RESET    (reset),
    .RX_DATA  (rx_data),
    .RX_VALID (rx_valid),
    .CMD_OUT  (cmd_out),
    .CMD_VALID(cmd_valid),
    .CMD_READY(cmd_ready),
    .OVERRUN  (overrun),
    .TIMEOUT  (timeout),
    .CSUM_ERR (csum_err),
    .BYTE_CNT (byte_cnt),
    .FRAME_CNT(frame_cnt)
  );

  typedef struct {
    logic        rst;
    logic        vld;
    logic [7:0]  data;
    logic        rdy;
    logic        cv;
    logic [39:0] out;
    logic [2:0]  bc;
    logic [15:0] fc;
    logic        ov;
    logic        to;
    logic        ce;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passed = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic checkAll(input string tag, input logic cv, input logic [39:0] out, input logic [2:0] bc,
                          input logic [15:0] fc, input logic ov, input logic to, input logic ce);
    checkOutput({tag, " CMD_VALID"}, 64'(cmd_valid), 64'(cv));
    checkOutput({tag, " CMD_OUT"},   64'(cmd_out),   64'(out));
    checkOutput({tag, " BYTE_CNT"},  64'(byte_cnt),  64'(bc));
    checkOutput({tag, " FRAME_CNT"}, 64'(frame_cnt), 64'(fc));
    checkOutput({tag, " OVERRUN"},   64'(overrun),   64'(ov));
    checkOutput({tag, " TIMEOUT"},   64'(timeout),   64'(to));
    checkOutput({tag, " CSUM_ERR"},  64'(csum_err),  64'(ce));
  endtask

  // Drive one cycle's inputs, let the edge happen, and settle before sampling.
  task automatic applyStimulus(input logic rst, input logic vld, input logic [7:0] data, input logic rdy);
    reset     = rst;
    rx_valid  = vld;
    rx_data   = data;
    cmd_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] sum8(input logic [39:0] w);
    logic [7:0] s = 8'h00;
    for (int i = 0; i < 5; i++) s = s + w[8*i +: 8];
    return s;
  endfunction

  // Full frame; CMD_READY is only raised on the completing byte.
  task automatic sendFrame(input logic [39:0] w, input logic rdy_last);
    applyStimulus(1'b0, 1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 1'b1, w[8*i +: 8], (i == FRAME_BYTES - 1) ? rdy_last : 1'b0);
`ifdef JTAG_CMD_RX_CHECKSUM_EN
    applyStimulus(1'b0, 1'b1, sum8(w), rdy_last);
`endif
  endtask

  function automatic void addVec(input logic rst, input logic vld, input logic [7:0] data, input logic rdy,
                                 input logic cv, input logic [39:0] out, input logic [2:0] bc,
                                 input logic [15:0] fc, input logic ov, input logic to, input logic ce);
    vecs.push_back('{rst, vld, data, rdy, cv, out, bc, fc, ov, to, ce});
  endfunction

  // Table rows for one clean frame of bytes 01..05; prior slot assumed empty.
  function automatic void addCleanFrame(input logic [15:0] fc_before);
    addVec(0, 1, 8'hA5, 0, 0, 40'h0504030201 & {40{fc_before != 0}}, 3'd0, fc_before, 0, 0, 0);
    for (int i = 1; i <= 4; i++)
      addVec(0, 1, 8'(i), 0, 0, 40'h0504030201 & {40{fc_before != 0}}, 3'(i), fc_before, 0, 0, 0);
`ifdef JTAG_CMD_RX_CHECKSUM_EN
    addVec(0, 1, 8'h05, 0, 0, 40'h0504030201 & {40{fc_before != 0}}, 3'd5, fc_before, 0, 0, 0);
    addVec(0, 1, 8'h0F, 0, 1, 40'h0504030201, 3'd0, fc_before + 16'd1, 0, 0, 0);
`else
    addVec(0, 1, 8'h05, 0, 1, 40'h0504030201, 3'd0, fc_before + 16'd1, 0, 0, 0);
`endif
  endfunction

  // Reference model: frame bytes collected in a queue, slot and counters as plain variables.
  logic [7:0]  m_q[$];
  bit          m_in_frame;
  int          m_idle;
  bit          m_valid;
  logic [39:0] m_out;
  logic [15:0] m_fc;
  bit          m_ov, m_to, m_ce;

  function automatic void modelReset();
    m_q.delete();
    m_in_frame = 0; m_idle = 0; m_valid = 0; m_out = '0; m_fc = '0;
    m_ov = 0; m_to = 0; m_ce = 0;
  endfunction

  function automatic void modelStep(input bit rst, input bit vld, input logic [7:0] data, input bit rdy);
    bit          deliver = 0;
    logic [39:0] word = '0;
    bit          was_valid = m_valid;
    if (rst) begin
      modelReset();
      return;
    end
    m_ov = 0; m_to = 0; m_ce = 0;
    if (vld) begin
      m_idle = 0;
      if (!m_in_frame) begin
        if (data == 8'hA5) begin
          m_in_frame = 1;
          m_q.delete();
        end
      end else begin
        m_q.push_back(data);
        if (m_q.size() == FRAME_BYTES) begin
          for (int i = 0; i < 5; i++) word = word | (40'(m_q[i]) << (8 * i));
`ifdef JTAG_CMD_RX_CHECKSUM_EN
          if (m_q[5] == sum8(word)) deliver = 1;
          else m_ce = 1;
`else
          deliver = 1;
`endif
          m_in_frame = 0;
        end
      end
    end else if (m_in_frame) begin
      m_idle++;
      if (m_idle == TO_CYC) begin
        m_to = 1;
        m_in_frame = 0;
      end
    end
    if (deliver) begin
      if (!was_valid || rdy) begin
        m_out = word; m_valid = 1; m_fc = m_fc + 16'd1;
      end else begin
        m_ov = 1;
      end
    end else if (was_valid && rdy) begin
      m_valid = 0;
    end
  endfunction

  function automatic logic [2:0] modelByteCnt();
    return m_in_frame ? 3'(m_q.size() > 5 ? 5 : m_q.size()) : 3'd0;
  endfunction

  initial begin
    // Vector table: reset, clean frame, consume, noise then a second clean frame.
    addVec(1, 0, 8'h00, 0, 0, 40'h0, 3'd0, 16'd0, 0, 0, 0);
    addCleanFrame(16'd0);
    addVec(0, 0, 8'h00, 0, 1, 40'h0504030201, 3'd0, 16'd1, 0, 0, 0);
    addVec(0, 0, 8'h00, 1, 0, 40'h0504030201, 3'd0, 16'd1, 0, 0, 0);
    addVec(0, 1, 8'h00, 0, 0, 40'h0504030201, 3'd0, 16'd1, 0, 0, 0);
    addVec(0, 1, 8'hFF, 0, 0, 40'h0504030201, 3'd0, 16'd1, 0, 0, 0);
    addVec(0, 1, 8'h13, 0, 0, 40'h0504030201, 3'd0, 16'd1, 0, 0, 0);
    addCleanFrame(16'd1);
    addVec(0, 0, 8'h00, 1, 0, 40'h0504030201, 3'd0, 16'd2, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].vld, vecs[i].data, vecs[i].rdy);
      checkAll($sformatf("vec%0d", i), vecs[i].cv, vecs[i].out, vecs[i].bc, vecs[i].fc,
               vecs[i].ov, vecs[i].to, vecs[i].ce);
    end

    // Overrun: second frame into a full slot is dropped, then accepted when READY coincides.
    applyStimulus(1, 0, 8'h00, 0);
    sendFrame(40'h0504030201, 1'b0);
    checkOutput("ovr first valid", 64'(cmd_valid), 64'd1);
    sendFrame(40'h5544332211, 1'b0);
    checkOutput("ovr pulse", 64'(overrun), 64'd1);
    checkOutput("ovr word kept", 64'(cmd_out), 64'h0504030201);
    checkOutput("ovr fc", 64'(frame_cnt), 64'd1);
    applyStimulus(0, 0, 8'h00, 0);
    checkOutput("ovr pulse end", 64'(overrun), 64'd0);
    sendFrame(40'hEEDDCCBBAA, 1'b1);
    checkOutput("ready swap ovr", 64'(overrun), 64'd0);
    checkOutput("ready swap word", 64'(cmd_out), 64'hEEDDCCBBAA);
    checkOutput("ready swap valid", 64'(cmd_valid), 64'd1);
    checkOutput("ready swap fc", 64'(frame_cnt), 64'd2);

    // Timeout after TO_CYC idle cycles mid-frame, then a clean frame.
    applyStimulus(1, 0, 8'h00, 0);
    applyStimulus(0, 1, 8'hA5, 0);
    applyStimulus(0, 1, 8'h11, 0);
    applyStimulus(0, 1, 8'h22, 0);
    for (int k = 1; k < TO_CYC; k++) begin
      applyStimulus(0, 0, 8'h00, 0);
      checkOutput($sformatf("to early %0d", k), 64'(timeout), 64'd0);
    end
    checkOutput("to bc before", 64'(byte_cnt), 64'd2);
    applyStimulus(0, 0, 8'h00, 0);
    checkOutput("to pulse", 64'(timeout), 64'd1);
    checkOutput("to bc", 64'(byte_cnt), 64'd0);
    applyStimulus(0, 0, 8'h00, 0);
    checkOutput("to pulse end", 64'(timeout), 64'd0);
    sendFrame(40'hEEDDCCBBAA, 1'b0);
    checkOutput("after to word", 64'(cmd_out), 64'hEEDDCCBBAA);
    checkOutput("after to valid", 64'(cmd_valid), 64'd1);

    // Byte landing on the expiry cycle wins; the counter restarts from it.
    applyStimulus(1, 0, 8'h00, 0);
    applyStimulus(0, 1, 8'hA5, 0);
    applyStimulus(0, 1, 8'h11, 0);
    applyStimulus(0, 1, 8'h22, 0);
    for (int k = 1; k < TO_CYC; k++) applyStimulus(0, 0, 8'h00, 0);
    applyStimulus(0, 1, 8'h33, 0);
    checkOutput("to race none", 64'(timeout), 64'd0);
    checkOutput("to race bc", 64'(byte_cnt), 64'd3);
    for (int k = 1; k < TO_CYC; k++) applyStimulus(0, 0, 8'h00, 0);
    checkOutput("to race later early", 64'(timeout), 64'd0);
    applyStimulus(0, 0, 8'h00, 0);
    checkOutput("to race later", 64'(timeout), 64'd1);

`ifdef JTAG_CMD_RX_CHECKSUM_EN
    // Bad checksum: frame discarded with a CSUM_ERR pulse.
    applyStimulus(1, 0, 8'h00, 0);
    applyStimulus(0, 1, 8'hA5, 0);
    for (int i = 1; i <= 5; i++) applyStimulus(0, 1, 8'(i), 0);
    applyStimulus(0, 1, 8'h10, 0);
    checkOutput("csum err", 64'(csum_err), 64'd1);
    checkOutput("csum valid", 64'(cmd_valid), 64'd0);
    checkOutput("csum fc", 64'(frame_cnt), 64'd0);
    applyStimulus(0, 0, 8'h00, 0);
    checkOutput("csum err end", 64'(csum_err), 64'd0);
`endif

    // Reset mid-frame with a held word, then decode from HUNT.
    applyStimulus(1, 0, 8'h00, 0);
    sendFrame(40'h0102030405, 1'b0);
    applyStimulus(0, 1, 8'hA5, 0);
    applyStimulus(0, 1, 8'h01, 0);
    applyStimulus(0, 1, 8'h02, 0);
    applyStimulus(1, 0, 8'h00, 0);
    checkAll("midreset", 0, 40'h0, 3'd0, 16'd0, 0, 0, 0);
    sendFrame(40'h0504030201, 1'b0);
    checkOutput("postreset word", 64'(cmd_out), 64'h0504030201);
    checkOutput("postreset fc", 64'(frame_cnt), 64'd1);

    // Randomized run against the reference model.
    applyStimulus(1, 0, 8'h00, 0);
    modelReset();
    for (int n = 0; n < 3000; n++) begin
      bit         r_rst = ($urandom_range(299) == 0);
      bit         r_vld = ($urandom_range(99) < 60);
      bit         r_rdy = ($urandom_range(99) < 30);
      logic [7:0] r_dat = ($urandom_range(99) < 20) ? 8'hA5 : 8'($urandom);
`ifdef JTAG_CMD_RX_CHECKSUM_EN
      if (m_in_frame && m_q.size() == 5 && $urandom_range(1) == 1) begin
        logic [39:0] w = '0;
        for (int i = 0; i < 5; i++) w = w | (40'(m_q[i]) << (8 * i));
        r_dat = sum8(w);
      end
`endif
      if ($urandom_range(39) == 0) begin
        int gap = $urandom_range(12, 6);
        for (int g = 0; g < gap; g++) begin
          bit g_rdy = ($urandom_range(99) < 30);
          modelStep(0, 0, 8'h00, g_rdy);
          applyStimulus(0, 0, 8'h00, g_rdy);
          checkAll($sformatf("rnd%0d gap%0d", n, g), m_valid, m_out, modelByteCnt(), m_fc, m_ov, m_to, m_ce);
        end
      end
      modelStep(r_rst, r_vld, r_dat, r_rdy);
      applyStimulus(r_rst, r_vld, r_dat, r_rdy);
      checkAll($sformatf("rnd%0d", n), m_valid, m_out, modelByteCnt(), m_fc, m_ov, m_to, m_ce);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/jtag_cmd_rx.md
Name: jtag_cmd_rx

Overview:
- Host-to-target half of the JTAG UART debug link; the existing 40-bit debug readback stream is the target-to-host half.
- Consumes the byte stream from the JTAG UART read port and hunts for a sync byte.
- Assembles 5 payload bytes, LSB first (same byte order as the readback stream), into a 40-bit command word.
- Presents the word to the debug controller through a one-entry valid/ready output register.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYC, 24'd9000000, max CLK_50 cycles between bytes inside a frame; 0 disables the timeout.
- CNT_W, 16, width of FRAME_CNT.

Ports:
- CLK_50  input  1  system clock; all logic on posedge.
- RESET  input  1  synchronous, active-high reset.
- RX_DATA  input  8  byte from JTAG UART read port.
- RX_VALID  input  1  one-cycle strobe; RX_DATA is valid this cycle. No backpressure.
- CMD_OUT  output  40  assembled command word.
- CMD_VALID  output  1  CMD_OUT holds an unconsumed word.
- CMD_READY  input  1  consumer accepts CMD_OUT when CMD_VALID && CMD_READY.
- OVERRUN  output  1  1-cycle pulse: completed frame dropped because the output slot was full.
- TIMEOUT  output  1  1-cycle pulse: partial frame abandoned.
- CSUM_ERR  output  1  1-cycle pulse: checksum mismatch (only with the optional feature; otherwise tied 0).
- BYTE_CNT  output  3  payload bytes captured in the current frame (0..5).
- FRAME_CNT  output  CNT_W  good frames delivered to the slot; wraps to 0.

Behaviour:
- Reset (RESET=1 at a posedge): state=HUNT; shift register=0; CMD_OUT=0; CMD_VALID=0; OVERRUN, TIMEOUT and CSUM_ERR all 0; BYTE_CNT=0; FRAME_CNT=0; timeout counter=0. Reset mid-frame discards the partial frame and any held word.
- HUNT:
  - RX_VALID with RX_DATA==SYNC_BYTE -> PAYLOAD, BYTE_CNT=0.
  - Any other byte is ignored.
- PAYLOAD: each RX_VALID byte goes to bits [8*BYTE_CNT+7 : 8*BYTE_CNT] and BYTE_CNT increments. A SYNC_BYTE value here is data, not a restart. On the 5th byte (BYTE_CNT 4->5):
  - without the feature, deliver and go to HUNT;
  - with the feature, go to CHECK.
- CHECK (feature only): the next RX_VALID byte is compared with the 8-bit mod-256 sum of the 5 payload bytes.
  - Match: deliver, go to HUNT.
  - Mismatch: CSUM_ERR pulse, discard, go to HUNT.
- Deliver, on the same cycle as the completing byte (CMD_VALID rises on the following edge, i.e. 1-cycle latency):
  - Slot empty, or slot full but CMD_READY=1 this cycle: CMD_OUT <= word, CMD_VALID <= 1, FRAME_CNT++. No overrun.
  - Slot full and CMD_READY=0: word dropped, OVERRUN pulse, CMD_OUT unchanged.
- Consume: CMD_VALID && CMD_READY with no delivery that cycle -> CMD_VALID <= 0. CMD_OUT holds its value while CMD_VALID=1.
- Timeout:
  - The counter runs only in PAYLOAD/CHECK.
  - It clears on every RX_VALID and on entering HUNT.
  - When it reaches TIMEOUT_CYC with no RX_VALID in that cycle: TIMEOUT pulse, BYTE_CNT=0, go to HUNT.
  - If RX_VALID coincides with expiry, the byte wins and there is no timeout.
- BYTE_CNT returns to 0 on entering HUNT.

Optional Feature:
- Macro: JTAG_CMD_RX_CHECKSUM_EN.
- Defined: CHECK state present; each frame is 7 bytes (sync, 5 payload, checksum); CSUM_ERR is live.
- Undefined: no CHECK state; each frame is 6 bytes; CSUM_ERR is constant 0; deliver happens on the 5th payload byte.

Test Plan:
- Reset, then feed A5 01 02 03 04 05 (plus checksum 0F if the feature is on) with CMD_READY=0 -> CMD_OUT=40'h0504030201, CMD_VALID=1, FRAME_CNT=1.
- Noise 00 FF 13 before A5 then a frame -> noise ignored; word identical to the clean case.
- Two frames back-to-back with CMD_READY=0 -> second frame dropped, OVERRUN pulses once, CMD_OUT still first word, FRAME_CNT=1. Repeat with CMD_READY=1 on the second frame's completing cycle -> second word loaded, no OVERRUN.
- TIMEOUT_CYC=10: A5 11 22, then 10 idle cycles -> TIMEOUT pulse, BYTE_CNT=0. Next frame A5 AA BB CC DD EE -> 40'hEEDDCCBBAA. A byte arriving on cycle 10 instead of idling -> no TIMEOUT.
- Feature on: A5 01 02 03 04 05 then 10 -> CSUM_ERR pulse, CMD_VALID stays 0, FRAME_CNT unchanged.
- RESET asserted after A5 01 02 -> all outputs 0; a following full frame decodes correctly from HUNT.
